shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register, the next generation of the team's D-latch and D flip-flop storage blocks. It extends them with arbitrary width, parallel load, clear, logical, arithmetic and rotate shifts in both directions, and a multi-cycle "shift by N" sequencer with a busy/done handshake. It sits between datapath registers and serial links, and serves as the shift stage for the arithmetic units.

## Interface
- WIDTH, 8, register width; must be 2 or more.
- AMT_W, 4, width of the shift-amount port.

- clk  in  1  clock; the register updates on the rising edge.
- reset  in  1  reset, asynchronous, active-low (0 = reset).
- mode  in  3  operation select. Encoding is in the shared package: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR.
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial input entering at the MSB on SHR.
- sin_r  in  1  serial input entering at bit 0 on SHL.
- start  in  1  request a multi-cycle shift of `amount` steps.
- amount  in  AMT_W  shift count, sampled with start.
- s1  out  WIDTH  register content q.
- s2  out  WIDTH  complement ~q.
- sout_l  out  1  q[WIDTH-1], combinational from q.
- sout_r  out  1  q[0], combinational from q.
- busy  out  1  high while a multi-cycle shift runs.
- done  out  1  one-cycle pulse when a multi-cycle shift completes.

## Operation
- Reset (reset=0): q=0 (s1=0, s2=all ones), state IDLE, busy=0, done=0, internal counter=0. All of these take effect immediately, without waiting for a clock edge.
- States: IDLE, RUN.
- IDLE with start=0: the current mode is applied once per edge.
  - HOLD keeps q.
  - LOAD sets q=d.
  - CLR sets q=0.
  - Shift modes apply one step per edge, so holding a shift mode shifts continuously.
- Step definitions:
  - SHL: q={q[W-2:0],sin_r}.
  - SHR: q={sin_l,q[W-1:1]}.
  - ROL and ROR rotate q by one position; bits wrap around.
  - ASR: q={q[W-1],q[W-1:1]}.
- IDLE with start=1 and a shift mode:
  - mode is latched as op_r and amount as cnt; the state moves to RUN.
  - q is not changed on this edge.
  - If amount=0, the state stays IDLE and done pulses on the next cycle.
- IDLE with start=1 and a non-shift mode: start is ignored and the mode executes as a normal direct operation.
- RUN: each edge applies op_r once and decrements cnt.
  - On the edge where cnt is 1, the final step is applied, the state returns to IDLE and done is set to 1 for exactly one cycle.
- While in RUN, mode, d, start and amount are all ignored. Serial inputs are still sampled on every step.
- amount larger than WIDTH is legal and runs the full count. For example, SHL by 10 on 8 bits fills q with sin_r; rotates wrap modulo WIDTH.
- s2 is always the exact bitwise complement of s1.

## Timing
- Direct operations take effect on the first rising edge after being presented.
- Multi-cycle shift with amount=N>0:
  - start is sampled on edge 0.
  - busy=1 from edge 0 until edge N.
  - The result is visible after edge N.
  - done=1 for the cycle between edge N and edge N+1.
- A new start is accepted in the same cycle done is high, because the state is already IDLE.
- busy and done are registered outputs and are never high at the same time.
- Reset asserted mid-RUN aborts the shift: q=0 and IDLE immediately. No done pulse is produced.
- After reset is released, the first rising edge performs normal IDLE behaviour.

## Structure
- The shared package shift_pkg holds the mode encoding constants, the state encoding (IDLE/RUN), and helper constants for AMT_W sizing.
- One natural sub-module is shift_cell: a per-bit 4:1 next-value mux (hold, load, left neighbour, right neighbour, plus clear) feeding a D flip-flop with active-low async clear. It is instantiated WIDTH times.
- End-bit neighbour selection (serial in, wrap-around, sign) and the sequencer FSM and counter live in the top module.

## Test plan
- Set q to a nonzero value, then drive reset=0 asynchronously between edges → s1=0x00, s2=0xFF, busy=0 and done=0 immediately.
- LOAD d=0xA5 → after the edge, s1=0xA5 and s2=0x5A. Then HOLD for 3 cycles → s1 stays 0xA5.
- With q=0x81, one ROL edge → 0x03. From 0x81, one ROR → 0xC0. SHR from 0x81 with sin_l=1 → 0xC0, sout_r=1 before the edge.
- With q=0x96, start ASR amount=3 → busy for 3 cycles, then q=0xF2 and done=1 for one cycle. Mode toggled to LOAD during busy is ignored.
- With q=0xFF, start SHL amount=10, sin_r=0 → q=0x00 after edge 10, busy high for 10 cycles, then a single done pulse.
- start with amount=0 → q unchanged, done pulses next cycle, busy stays 0. In a separate run, start ROR amount=5 and assert reset at busy cycle 2 → q=0x00, busy=0, and no done pulse.

Source files
------------

// File: rtl/shift_reg_univ_pkg.sv
// Shared encodings for the universal shift register: operation modes, sequencer
// states, per-bit cell selects and default sizing.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // FROM_LO takes the lower-index neighbour (left shift), FROM_HI the upper one.
    typedef enum logic [1:0] {
        CELL_HOLD    = 2'b00,
        CELL_LOAD    = 2'b01,
        CELL_FROM_LO = 2'b10,
        CELL_FROM_HI = 2'b11
    } cell_sel_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_AMT_W = 4;

    function automatic logic is_shift(mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle between a requester and the universal shift register.
interface shift_reg_univ_if
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
);
    mode_e              mode;
    logic [WIDTH-1:0]   d;
    logic               sin_l;
    logic               sin_r;
    logic               start;
    logic [AMT_W-1:0]   amount;
    logic [WIDTH-1:0]   s1;
    logic [WIDTH-1:0]   s2;
    logic               sout_l;
    logic               sout_r;
    logic               busy;
    logic               done;

    modport master (
        output mode, d, sin_l, sin_r, start, amount,
        input  s1, s2, sout_l, sout_r, busy, done
    );

    modport slave (
        input  mode, d, sin_l, sin_r, start, amount,
        output s1, s2, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/shift_reg_univ_cell.sv
// One storage bit: next-value mux (hold/load/neighbours) with clear priority,
// feeding a flip-flop with active-low asynchronous clear.
module shift_cell
    import shift_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  cell_sel_e sel_i,
    input  logic      clr_i,
    input  logic      load_i,
    input  logic      from_lo_i,
    input  logic      from_hi_i,
    output logic      q_o
);
    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case (sel_i)
            CELL_HOLD:    q_d = q_q;
            CELL_LOAD:    q_d = load_i;
            CELL_FROM_LO: q_d = from_lo_i;
            CELL_FROM_HI: q_d = from_hi_i;
            default:      q_d = q_q;
        endcase
        if (clr_i) begin
            q_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: per-bit cells plus end-bit feed selection and a
// "shift by N" sequencer with busy/done handshake. reset is active-low, async.
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    shift_reg_univ_if.slave  bus
);
    state_e           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    mode_e            op_q, op_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] q;
    mode_e            eff_op;
    cell_sel_e        sel;
    logic             clr;
    logic             lo_in;
    logic             hi_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MODE_HOLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            done_q  <= done_d;
        end
    end

    // A zero-length request completes at once: stay idle and pulse done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && is_shift(bus.mode)) begin
                    op_d  = bus.mode;
                    cnt_d = bus.amount;
                    if (bus.amount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eff_op = bus.mode;
        if (state_q == ST_RUN) begin
            eff_op = op_q;
        end else if (bus.start && is_shift(bus.mode)) begin
            eff_op = MODE_HOLD;
        end

        sel   = CELL_HOLD;
        clr   = 1'b0;
        lo_in = 1'b0;
        hi_in = 1'b0;
        case (eff_op)
            MODE_HOLD: sel = CELL_HOLD;
            MODE_LOAD: sel = CELL_LOAD;
            MODE_CLR:  clr = 1'b1;
            MODE_SHL: begin sel = CELL_FROM_LO; lo_in = bus.sin_r;    end
            MODE_ROL: begin sel = CELL_FROM_LO; lo_in = q[WIDTH-1];   end
            MODE_SHR: begin sel = CELL_FROM_HI; hi_in = bus.sin_l;    end
            MODE_ROR: begin sel = CELL_FROM_HI; hi_in = q[0];         end
            MODE_ASR: begin sel = CELL_FROM_HI; hi_in = q[WIDTH-1];   end
            default:  sel = CELL_HOLD;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic from_lo;
        logic from_hi;
        if (i == 0) begin : g_lo_end
            assign from_lo = lo_in;
        end else begin : g_lo_mid
            assign from_lo = q[i-1];
        end
        if (i == WIDTH-1) begin : g_hi_end
            assign from_hi = hi_in;
        end else begin : g_hi_mid
            assign from_hi = q[i+1];
        end
        shift_cell u_cell (
            .clk       (clk),
            .rst_n     (reset),
            .sel_i     (sel),
            .clr_i     (clr),
            .load_i    (bus.d[i]),
            .from_lo_i (from_lo),
            .from_hi_i (from_hi),
            .q_o       (q[i])
        );
    end

    assign bus.s1     = q;
    assign bus.s2     = ~q;
    assign bus.sout_l = q[WIDTH-1];
    assign bus.sout_r = q[0];
    assign bus.busy   = (state_q == ST_RUN);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: a table of single-edge operations plus
// hand-written multi-cycle sequences (shift-by-N, zero count, reset abort).
module tb_shift_reg_univ;
    import shift_pkg::*;

    typedef struct {
        mode_e      mode;
        logic [7:0] d;
        logic       sinL;
        logic       sinR;
        logic [7:0] expS1;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vecs[17];

    shift_reg_univ_if #(.WIDTH(8), .AMT_W(4)) bus ();

    shift_reg_univ #(.WIDTH(8), .AMT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expS1,
                               input logic expBusy, input logic expDone);
        checkVal({name, "/s1"}, bus.s1, expS1);
        checkVal({name, "/s2"}, bus.s2, ~expS1);
        checkVal({name, "/sout_l"}, {7'b0, bus.sout_l}, {7'b0, expS1[7]});
        checkVal({name, "/sout_r"}, {7'b0, bus.sout_r}, {7'b0, expS1[0]});
        checkVal({name, "/busy"}, {7'b0, bus.busy}, {7'b0, expBusy});
        checkVal({name, "/done"}, {7'b0, bus.done}, {7'b0, expDone});
    endtask

    task automatic applyStimulus(input mode_e mode, input logic [7:0] d, input logic sinL,
                                 input logic sinR, input logic start, input logic [3:0] amount);
        bus.mode   = mode;
        bus.d      = d;
        bus.sin_l  = sinL;
        bus.sin_r  = sinR;
        bus.start  = start;
        bus.amount = amount;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start on edge 0, scramble mode/d while busy, expect done right after edge n.
    task automatic runMulti(input string name, input mode_e mode, input logic [3:0] n,
                            input logic sinL, input logic sinR,
                            input logic [7:0] startVal, input logic [7:0] expFinal);
        applyStimulus(mode, 8'h00, sinL, sinR, 1'b1, n);
        tick();
        checkOutput({name, "/edge0"}, startVal, 1'b1, 1'b0);
        applyStimulus(MODE_LOAD, 8'h00, sinL, sinR, 1'b0, 4'd0);
        for (int i = 1; i <= int'(n); i++) begin
            if (i == int'(n)) bus.mode = MODE_HOLD;
            tick();
            if (i < int'(n)) begin
                checkVal({name, "/busy"}, {7'b0, bus.busy}, 8'h01);
                checkVal({name, "/done"}, {7'b0, bus.done}, 8'h00);
            end else begin
                checkOutput({name, "/final"}, expFinal, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[1]  = '{MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'hA5};
        vecs[2]  = '{MODE_HOLD, 8'h11, 1'b1, 1'b1, 8'hA5};
        vecs[3]  = '{MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'hA5};
        vecs[4]  = '{MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[5]  = '{MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h03};
        vecs[6]  = '{MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[7]  = '{MODE_ROR,  8'h00, 1'b0, 1'b0, 8'hC0};
        vecs[8]  = '{MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81};
        vecs[9]  = '{MODE_SHR,  8'h00, 1'b1, 1'b0, 8'hC0};
        vecs[10] = '{MODE_SHL,  8'h00, 1'b0, 1'b1, 8'h81};
        vecs[11] = '{MODE_ASR,  8'h00, 1'b0, 1'b0, 8'hC0};
        vecs[12] = '{MODE_CLR,  8'hFF, 1'b1, 1'b1, 8'h00};
        vecs[13] = '{MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C};
        vecs[14] = '{MODE_ASR,  8'h00, 1'b1, 1'b1, 8'h1E};
        vecs[15] = '{MODE_SHR,  8'h00, 1'b0, 1'b1, 8'h0F};
        vecs[16] = '{MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h1E};

        reset = 1'b0;
        applyStimulus(MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        #12;
        reset = 1'b1;
        tick();
        checkOutput("after_reset", 8'h00, 1'b0, 1'b0);

        applyStimulus(MODE_LOAD, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("preload", 8'h3C, 1'b0, 1'b0);
        bus.mode = MODE_HOLD;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].d, vecs[i].sinL, vecs[i].sinR, 1'b0, 4'd0);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].expS1, 1'b0, 1'b0);
        end

        applyStimulus(MODE_LOAD, 8'h96, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        runMulti("asr3", MODE_ASR, 4'd3, 1'b0, 1'b0, 8'h96, 8'hF2);
        applyStimulus(MODE_ROL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1);
        tick();
        checkOutput("restart_in_done", 8'hF2, 1'b1, 1'b0);
        applyStimulus(MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("rol1_done", 8'hE5, 1'b0, 1'b1);
        tick();
        checkOutput("rol1_after", 8'hE5, 1'b0, 1'b0);

        applyStimulus(MODE_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        runMulti("shl10", MODE_SHL, 4'd10, 1'b0, 1'b0, 8'hFF, 8'h00);
        tick();
        checkOutput("shl10_after", 8'h00, 1'b0, 1'b0);

        applyStimulus(MODE_LOAD, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        applyStimulus(MODE_SHL, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        checkOutput("amt0_done", 8'h5A, 1'b0, 1'b1);
        applyStimulus(MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        checkOutput("amt0_after", 8'h5A, 1'b0, 1'b0);

        applyStimulus(MODE_ROR, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
        tick();
        checkOutput("ror5_edge0", 8'h5A, 1'b1, 1'b0);
        applyStimulus(MODE_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        checkVal("ror5_busy2", {7'b0, bus.busy}, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ror5_abort", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("post_abort%0d", i), 8'h00, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
